circle_cmd_scheduler: RTL and testbench
=======================================

Name: circle_cmd_scheduler

Overview:
Front-end controller for the circle-drawing engine.
- Queues circle draw commands (radius, colour) from a host through a valid/ready FIFO.
- Optionally clears the 160x120 VGA framebuffer.
- Sequences the engine one command at a time using its draw/done handshake.
- Owns the single VGA plot port: it muxes its own clear-pixel stream and the engine's pixel stream onto vga_x/vga_y/vga_colour/vga_plot.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of 2, minimum 2).
- CLEAR_ON_RESET, 1, when 1, enter CLEAR automatically after reset.
- CLEAR_COLOUR, 3'b000, colour written during a clear.
- SCREEN_W, 160, framebuffer width in pixels.
- SCREEN_H, 120, framebuffer height in pixels.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  queue can accept a command (not full).
- cmd_radius  in  5  radius of the queued circle.
- cmd_colour  in  3  colour of the queued circle.
- clear_req  in  1  single-cycle pulse requesting a screen clear.
- busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty.
- eng_draw  out  1  single-cycle start pulse to the engine.
- eng_radius  out  5  radius to the engine, held stable from ISSUE until done.
- eng_colour  out  3  colour to the engine, held stable from ISSUE until done.
- eng_done  in  1  engine has finished the current circle (pulse or level).
- eng_x  in  8  engine pixel x.
- eng_y  in  7  engine pixel y.
- eng_vcolour  in  3  engine pixel colour.
- eng_plot  in  1  engine pixel strobe.
- vga_x  out  8  pixel x to the VGA adapter.
- vga_y  out  7  pixel y to the VGA adapter.
- vga_colour  out  3  pixel colour to the VGA adapter.
- vga_plot  out  1  pixel write strobe to the VGA adapter.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - FIFO emptied; clear_pend=0.
  - vga_x/y/colour=0, vga_plot=0, eng_draw=0, eng_radius/eng_colour=0.
  - State goes to RST.
- Push: a command is accepted on a cycle where cmd_valid and cmd_ready are both 1. cmd_valid while full is ignored (no overwrite).
- cmd_ready = !full, computed from registered occupancy. It is therefore 1 on the first cycle after reset.
- Simultaneous push and pop: occupancy is unchanged and both complete. This is also legal when full, but cmd_ready=0 when full, so no push occurs then.
- FSM states: RST, IDLE, CLEAR, ISSUE, WAIT.
- RST: go to CLEAR if CLEAR_ON_RESET, else IDLE. Lasts one cycle.
- IDLE priority:
  - clear_req or clear_pend -> CLEAR, and clear_pend is cleared.
  - otherwise FIFO non-empty -> ISSUE.
  - clear always wins over queued commands.
- CLEAR:
  - Each cycle registers vga_plot=1, vga_colour=CLEAR_COLOUR and (vga_x, vga_y) = (cx, cy).
  - Counters start at (0,0). cx increments; at SCREEN_W-1 it wraps to 0 and cy increments.
  - After plotting (SCREEN_W-1, SCREEN_H-1) -> IDLE.
  - Exactly SCREEN_W*SCREEN_H = 19200 strobes, row-major, one per cycle. No pixel is repeated or skipped.
- ISSUE (one cycle):
  - Pop the FIFO head into eng_radius/eng_colour registers.
  - Assert eng_draw on the following cycle for exactly 1 cycle.
  - -> WAIT.
- WAIT:
  - vga_x/y/colour/plot are a combinational pass-through of eng_x/eng_y/eng_vcolour/eng_plot.
  - eng_done=1 -> IDLE. eng_done is ignored in every other state.
- clear_req arriving in CLEAR, ISSUE or WAIT sets clear_pend. Multiple requests collapse to one.
- vga_plot=0 in RST, IDLE and ISSUE.
- Mid-operation reset aborts CLEAR or WAIT immediately: vga_plot=0 on the next cycle and queued commands are lost.
- Width rules:
  - cx is 8 bits, cy is 7 bits; both compare against parameter minus 1.
  - FIFO pointers are log2(FIFO_DEPTH) bits with wrap-around; occupancy uses one extra bit.

Decomposition:
- Package circle_pkg:
  - state enum (RST, IDLE, CLEAR, ISSUE, WAIT);
  - cmd_t struct {radius[4:0], colour[2:0]};
  - SCREEN_W/SCREEN_H defaults;
  - width constants X_W=8, Y_W=7, C_W=3.
- One sub-module, cmd_fifo: synchronous FIFO of cmd_t with push, pop, full, empty and count.
- FSM, clear counters and VGA mux stay in the top level.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, then release -> exactly 19200 vga_plot strobes with colour 000; first (0,0), last (159,119); row-major with no gaps; busy drops afterwards.
2. Push {31,101} while idle -> one-cycle eng_draw with eng_radius=31 and eng_colour=101; engine pixels appear unchanged on vga_*; eng_done returns to IDLE.
3. Push 5 commands back-to-back with the engine stalled (DEPTH=4, first already popped) -> cmd_ready=0 after the 5th push; a 6th push is dropped; commands issue in FIFO order.
4. clear_req during WAIT -> no extra eng_draw until done; then the CLEAR sequence (19200 strobes) runs before the next queued command.
5. rstn=0 for 1 cycle midway through CLEAR -> vga_plot=0 next cycle; the FIFO is empty; the clear restarts at (0,0).
6. Simultaneous push and pop at occupancy 2 -> occupancy stays 2; no command is lost or duplicated.

Source files
------------

// File: rtl/circle_pkg.sv
// Shared types and constants for the circle-drawing front end.
// Command bundle, scheduler states and screen geometry.
package circle_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int R_W = 5;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {
    RST,
    IDLE,
    CLEAR,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [R_W-1:0] radius;
    logic [C_W-1:0] colour;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue with occupancy count.
// Push while full and pop while empty are ignored.
module cmd_fifo
  import circle_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic        pop,
  input  cmd_t        wdata,
  output cmd_t        rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  cmd_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/circle_cmd_scheduler.sv
// Queues circle commands, sequences the engine and owns the VGA port.
// Clear pixels come from registered counters; engine pixels pass through.
module circle_cmd_scheduler
  import circle_pkg::*;
#(
  parameter int             FIFO_DEPTH     = 4,
  parameter bit             CLEAR_ON_RESET = 1'b1,
  parameter logic [C_W-1:0] CLEAR_COLOUR   = 3'b000,
  parameter int             SCREEN_W       = SCREEN_W_DEF,
  parameter int             SCREEN_H       = SCREEN_H_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [R_W-1:0] cmd_radius,
  input  logic [C_W-1:0] cmd_colour,
  input  logic           clear_req,
  output logic           busy,
  output logic           eng_draw,
  output logic [R_W-1:0] eng_radius,
  output logic [C_W-1:0] eng_colour,
  input  logic           eng_done,
  input  logic [X_W-1:0] eng_x,
  input  logic [Y_W-1:0] eng_y,
  input  logic [C_W-1:0] eng_vcolour,
  input  logic           eng_plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t         state;
  state_t         state_nxt;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           clear_pend;
  logic           pop;
  logic           last_x;
  logic           last_y;
  cmd_t           wcmd;
  cmd_t           head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;

  assign wcmd      = '{radius: cmd_radius, colour: cmd_colour};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign last_x    = (cx == X_W'(SCREEN_W - 1));
  assign last_y    = (cy == Y_W'(SCREEN_H - 1));

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (cmd_valid),
    .pop  (pop),
    .wdata(wcmd),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      RST:   state_nxt = CLEAR_ON_RESET ? CLEAR : IDLE;
      IDLE: begin
        if (clear_req || clear_pend) state_nxt = CLEAR;
        else if (!fifo_empty)        state_nxt = ISSUE;
      end
      CLEAR: if (last_x && last_y) state_nxt = IDLE;
      ISSUE: begin
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (eng_done) state_nxt = IDLE;
      default: state_nxt = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= RST;
      clear_pend <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      eng_draw   <= 1'b0;
      eng_radius <= '0;
      eng_colour <= '0;
    end else begin
      state    <= state_nxt;
      eng_draw <= (state == ISSUE);
      if (state == ISSUE) begin
        eng_radius <= head.radius;
        eng_colour <= head.colour;
      end
      // IDLE consumes any pending request on its way into CLEAR
      if (state == IDLE)
        clear_pend <= 1'b0;
      else if (clear_req && state != RST)
        clear_pend <= 1'b1;
      if (state == CLEAR) begin
        if (last_x) begin
          cx <= '0;
          cy <= last_y ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end else begin
        cx <= '0;
        cy <= '0;
      end
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        vga_x      = cx;
        vga_y      = cy;
        vga_colour = CLEAR_COLOUR;
        vga_plot   = 1'b1;
      end
      (state == WAIT): begin
        vga_x      = eng_x;
        vga_y      = eng_y;
        vga_colour = eng_vcolour;
        vga_plot   = eng_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_circle_cmd_scheduler.sv
// Directed bench for the circle command scheduler.
// Engine is modelled by hand-driven done/pixel inputs.
module tb_circle_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_radius;
  logic [2:0] cmd_colour;
  logic       clear_req;
  logic       busy;
  logic       eng_draw;
  logic [4:0] eng_radius;
  logic [2:0] eng_colour;
  logic       eng_done;
  logic [7:0] eng_x;
  logic [6:0] eng_y;
  logic [2:0] eng_vcolour;
  logic       eng_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int checks = 0;
  int errors = 0;
  logic [7:0] draws[$];

  always #5 clk = ~clk;

  circle_cmd_scheduler #(
    .FIFO_DEPTH    (4),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_COLOUR  (3'b000),
    .SCREEN_W      (160),
    .SCREEN_H      (120)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_radius (cmd_radius),
    .cmd_colour (cmd_colour),
    .clear_req  (clear_req),
    .busy       (busy),
    .eng_draw   (eng_draw),
    .eng_radius (eng_radius),
    .eng_colour (eng_colour),
    .eng_done   (eng_done),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_vcolour(eng_vcolour),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always @(negedge clk)
    if (eng_draw === 1'b1) draws.push_back({eng_radius, eng_colour});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [2:0] c);
    cmd_valid  = 1'b1;
    cmd_radius = r;
    cmd_colour = c;
    tick;
    cmd_valid  = 1'b0;
  endtask

  task automatic serve;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
  endtask

  task automatic wait_draw(input string tag);
    int w = 0;
    while (eng_draw !== 1'b1 && w < 50) begin
      tick;
      w++;
    end
    chk({tag, "_draw"}, eng_draw, 1);
  endtask

  task automatic run_clear(input string tag);
    int w = 0;
    int n = 0;
    int bad = 0;
    logic [7:0] ex = 0;
    logic [6:0] ey = 0;
    logic [7:0] lx = 0;
    logic [6:0] ly = 0;
    while (vga_plot !== 1'b1 && w < 100) begin
      tick;
      w++;
    end
    chk({tag, "_start"}, vga_plot, 1);
    while (vga_plot === 1'b1 && n < 20000) begin
      if (vga_x !== ex || vga_y !== ey || vga_colour !== 3'b000) bad++;
      lx = vga_x;
      ly = vga_y;
      n++;
      if (ex == 8'd159) begin
        ex = 0;
        ey++;
      end else begin
        ex++;
      end
      tick;
    end
    chk({tag, "_count"}, n, 19200);
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_last_x"}, lx, 159);
    chk({tag, "_last_y"}, ly, 119);
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_radius = '0;
    cmd_colour = '0;
    clear_req = 1'b0;
    eng_done = 1'b0;
    eng_x = '0;
    eng_y = '0;
    eng_vcolour = '0;
    eng_plot = 1'b0;

    tick;
    tick;
    chk("rst_plot", vga_plot, 0);
    chk("rst_draw", eng_draw, 0);
    chk("rst_radius", eng_radius, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 1);

    rstn = 1'b1;
    run_clear("clr1");
    chk("clr1_busy", busy, 0);

    // single command, engine pixel pass-through
    chk("t2_ready", cmd_ready, 1);
    push(5'd31, 3'b101);
    wait_draw("t2");
    chk("t2_radius", eng_radius, 31);
    chk("t2_colour", eng_colour, 3'b101);
    tick;
    chk("t2_draw_1cyc", eng_draw, 0);
    eng_x = 8'd77;
    eng_y = 7'd33;
    eng_vcolour = 3'b110;
    eng_plot = 1'b1;
    #1;
    chk("t2_pass_x", vga_x, 77);
    chk("t2_pass_y", vga_y, 33);
    chk("t2_pass_c", vga_colour, 3'b110);
    chk("t2_pass_p", vga_plot, 1);
    eng_plot = 1'b0;
    #1;
    chk("t2_pass_p0", vga_plot, 0);
    serve;
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_plot", vga_plot, 0);

    // fill queue with engine stalled
    for (int i = 1; i <= 5; i++) push(5'(i), 3'(i));
    chk("t3_full", cmd_ready, 0);
    push(5'd6, 3'd6);
    chk("t3_still_full", cmd_ready, 0);
    chk("t3_one_draw", draws.size(), 2);
    serve;
    wait_draw("t3_b");

    // clear request while engine busy
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    repeat (5) tick;
    chk("t4_no_extra", draws.size(), 3);
    serve;
    run_clear("clr2");
    chk("t4_no_draw_in_clr", draws.size(), 3);
    for (int i = 0; i < 3; i++) begin
      wait_draw("t3_rest");
      serve;
    end
    repeat (5) tick;
    chk("t3_total", draws.size(), 6);
    for (int i = 0; i < 5; i++)
      chk("t3_order", draws[1+i], {5'(i+1), 3'(i+1)});
    chk("t3_busy", busy, 0);

    // reset in the middle of a clear with a queued command
    clear_req = 1'b1;
    push(5'd7, 3'd7);
    clear_req = 1'b0;
    repeat (100) tick;
    chk("t5_clearing", vga_plot, 1);
    rstn = 1'b0;
    tick;
    chk("t5_abort_plot", vga_plot, 0);
    chk("t5_abort_draw", eng_draw, 0);
    rstn = 1'b1;
    run_clear("clr3");
    repeat (5) tick;
    chk("t5_fifo_empty", busy, 0);
    chk("t5_no_draw", draws.size(), 6);

    // push during the pop cycle at occupancy 2
    push(5'd8, 3'd0);
    push(5'd9, 3'd1);
    push(5'd10, 3'd2);
    chk("t6_ready_occ2", cmd_ready, 1);
    push(5'd11, 3'd3);
    chk("t6_ready_occ3", cmd_ready, 1);
    push(5'd12, 3'd4);
    chk("t6_full_occ4", cmd_ready, 0);
    serve;
    for (int i = 0; i < 4; i++) begin
      wait_draw("t6");
      serve;
    end
    repeat (5) tick;
    chk("t6_total", draws.size(), 11);
    for (int i = 0; i < 5; i++)
      chk("t6_order", draws[6+i], {5'(8+i), 3'(i)});
    chk("t6_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
